// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM core inter-stage registers: control-vector bit
// indices, per-stage vector widths and data-vector field offsets.
package arm_pipe_pkg;

    // Control-vector bit indices
    localparam int unsigned CTRL_WB_EN    = 0;
    localparam int unsigned CTRL_MEM_R_EN = 1;
    localparam int unsigned CTRL_MEM_W_EN = 2;
    localparam int unsigned CTRL_B        = 3;
    localparam int unsigned CTRL_S        = 4;
    localparam int unsigned CTRL_IMM      = 5;

    // Per-stage vector widths
    localparam int unsigned IF_ID_CTRL_W  = 8;
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_CTRL_W  = 8;
    localparam int unsigned ID_EX_DATA_W  = 160;
    localparam int unsigned EX_MEM_CTRL_W = 8;
    localparam int unsigned EX_MEM_DATA_W = 72;
    localparam int unsigned MEM_WB_CTRL_W = 8;
    localparam int unsigned MEM_WB_DATA_W = 72;

    // Data-vector field offsets (LSB position) for the ID/EX layout
    localparam int unsigned OFS_PC       = 0;
    localparam int unsigned OFS_VAL_RN   = 32;
    localparam int unsigned OFS_VAL_RM   = 64;
    localparam int unsigned OFS_SHIFT_OP = 96;
    localparam int unsigned OFS_IMM24    = 108;
    localparam int unsigned OFS_DEST     = 132;
    localparam int unsigned OFS_SR       = 136;
    localparam int unsigned OFS_SRC1     = 140;
    localparam int unsigned OFS_SRC2     = 144;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer, hazard bubble input
// and synchronous flush. MAIN drives the outputs; SKID absorbs one item of back-pressure.
module pipe_stage_skid_reg
    import arm_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = ID_EX_CTRL_W,
    parameter int unsigned DATA_W     = ID_EX_DATA_W,
    parameter bit          FLUSH_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic accept;
    logic drain;

    assign in_ready  = !skid_valid_q && !bubble;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid_q && out_ready;

    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // Handshakes in the flush cycle are dropped; upstream is flushed too.
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            if (FLUSH_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end
        end else if (drain) begin
            if (skid_valid_q) begin
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end else if (accept) begin
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else begin
                // Empty MAIN shows a NOP control vector downstream.
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised elastic pipeline stage register for the ARM core. It replaces fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a control vector and a data vector under a valid/ready handshake. It adds a 2-entry skid buffer, a hazard-bubble input and a synchronous flush. It sits between any two pipeline stages; the hazard unit drives `bubble` and the branch logic drives `flush`.

## Interface
- `CTRL_W`, default 8: width of the control vector (WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, …); cleared on flush/empty.
- `DATA_W`, default 160: width of the data vector (PC, Val_Rn, Val_Rm, shift operand, imm24, dest, SR, src1/src2 …).
- `FLUSH_DATA`, default 1: 1 = data vector zeroed on flush; 0 = data holds its last value (saves power and area).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  synchronous kill of every entry held in the stage.
- `bubble`  in  1  hazard stall; blocks input acceptance this cycle.
- `in_valid`  in  1  upstream has an item.
- `in_ready`  out  1  stage accepts an item this cycle.
- `in_ctrl`  in  CTRL_W  upstream control vector.
- `in_data`  in  DATA_W  upstream data vector.
- `out_valid`  out  1  main entry holds a valid item.
- `out_ready`  in  1  downstream consumes the item this cycle.
- `out_ctrl`  out  CTRL_W  main-entry control; all-zero whenever `out_valid`=0.
- `out_data`  out  DATA_W  main-entry data.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Two entries: MAIN (drives the outputs) and SKID (overflow). Each entry has a valid bit.
- `in_ready = !skid_valid && !bubble`. This is combinational from `bubble` only; `skid_valid` is a register.
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- Priority, highest first: `rst` > `flush` > normal update.
- Normal update per cycle:
  - MAIN empty, accept: MAIN ← in.
  - MAIN full, drain, SKID empty, accept: MAIN ← in.
  - MAIN full, drain, SKID empty, no accept: MAIN becomes empty.
  - MAIN full, drain, SKID full: MAIN ← SKID and SKID empties. Accept is impossible in this case because `in_ready`=0.
  - MAIN full, no drain, accept: SKID ← in.
  - Any other combination: hold.
- Whenever MAIN becomes empty, its control register is written to 0. A drained bubble therefore looks like a NOP downstream (no WB, no memory access, no branch, no flag update).
- `flush`:
  - Both entries become invalid and both control registers are cleared.
  - Data registers are cleared if `FLUSH_DATA`=1; otherwise they hold.
  - A handshake on either side in the flush cycle is discarded. Upstream counts it as consumed, since upstream is being flushed too.
- `bubble`:
  - Input acceptance is blocked for that cycle only.
  - The output side keeps draining normally, so a bubble reaches downstream as `out_valid`=0 with zero control.
- `occupancy` = `main_valid + skid_valid`. The state `skid_valid`=1 with `main_valid`=0 is illegal and never reachable.

## Timing
- Reset values, all asynchronous: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, SKID cleared. `in_ready` reads 1 after reset if `bubble`=0.
- Latency: an item accepted at edge N appears on `out_*` after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: one item per cycle with `out_ready` held at 1. The skid buffer is never used in that case.
- Back-pressure:
  - The first item arriving while MAIN is stalled goes to SKID.
  - `in_ready` falls in the following cycle.
  - After `out_ready` returns, SKID moves into MAIN on that edge, and `in_ready` rises in the next cycle.
- Flush: `out_valid`=0 and `occupancy`=0 in the cycle after the flush edge. An accept in that next cycle is handled normally.
- Reset asserted mid-stall clears everything immediately, independent of `clk`.

## Structure
- Shared package `arm_pipe_pkg`:
  - Control-vector bit indices (WB_EN, MEM_R_EN, MEM_W_EN, B, S, IMM).
  - Per-stage `CTRL_W`/`DATA_W` constants.
  - Data-field offsets (PC, VAL_RN, VAL_RM, SHIFT_OP, IMM24, DEST, SR, SRC1, SRC2).
- Single module, with no sub-modules. Stage wrappers pack and unpack fields using the package offsets.

## Test plan
- Reset with `in_valid`=1 and `in_ctrl`=8'hFF → `out_valid`=0, `out_ctrl`=0, `occupancy`=0; `in_ready`=1 once `rst` falls.
- Stream A, B, C with `out_ready`=1 → outputs A, B, C in consecutive cycles, each one cycle after acceptance; `occupancy` never exceeds 1.
- `out_ready`=0, send A then B → A held on the outputs, B in SKID, `occupancy`=2, `in_ready`=0. Then `out_ready`=1 → B on the next cycle, then `in_ready`=1, and no item lost or duplicated.
- `occupancy`=2, assert `flush` together with `in_valid`=1 (item D) → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0. `out_data`=0 when `FLUSH_DATA`=1; `out_data` unchanged when `FLUSH_DATA`=0. D never appears.
- `bubble`=1 for one cycle during the stream A, B, C with `out_ready`=1 → `in_ready`=0 that cycle; output sequence A, bubble (`out_valid`=0, `out_ctrl`=0), B, C.
- Assert `rst` asynchronously mid-cycle while `occupancy`=2 → outputs zero immediately, before the next edge; resume streaming with no stale items.
